// File: rtl/sprite_plotter_if.sv
// Request/status, sprite ROM and VGA pixel signals between the pet FSM side and the sprite plotter.
// The master side raises requests and returns ROM data; the slave side is the plotter.
interface sprite_plotter_if #(
    parameter int ROM_AW = 12
);
    logic              plot_req;
    logic              move_req;
    logic [11:0]       draw_sel;
    logic [ROM_AW-1:0] rom_addr;
    logic [2:0]        rom_data;
    logic              plot_busy;
    logic              move_busy;
    logic              bubble_drawn;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;

    modport master (
        output plot_req, move_req, draw_sel, rom_data,
        input  rom_addr, plot_busy, move_busy, bubble_drawn,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  plot_req, move_req, draw_sel, rom_data,
        output rom_addr, plot_busy, move_busy, bubble_drawn,
        output vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/sprite_plotter.sv
// Sprite plotter: sweeps a selected object's sprite ROM into VGA pixel writes, or animates it (erase/step/redraw).
// Latency: first pixel 2 cycles after a plot request, busy drops W*H+2 cycles after it.
// Backpressure: none; level requests are held until the block returns to idle, busy flags stay up meanwhile.
module sprite_plotter #(
    parameter int          X_SCREEN_PIXELS = 160,
    parameter int          Y_SCREEN_PIXELS = 120,
    parameter int          SPRITE_W        = 16,
    parameter int          SPRITE_H        = 16,
    parameter int          ROM_AW          = 12,
    parameter int          FRAME_TICKS     = 833333,
    parameter int          MOVE_STEPS      = 8,
    parameter logic [2:0]  BG_COLOUR       = 3'b011,
    parameter logic [95:0] ORIGIN_X        = {8'd130, 8'd130, 8'd40, 8'd40, 8'd100, 8'd96,
                                              8'd96, 8'd96, 8'd96, 8'd96, 8'd88, 8'd72},
    parameter logic [83:0] ORIGIN_Y        = {7'd80, 7'd80, 7'd80, 7'd80, 7'd50, 7'd30,
                                              7'd30, 7'd30, 7'd30, 7'd30, 7'd40, 7'd52}
) (
    input logic           clk,
    input logic           resetn,
    sprite_plotter_if.slave bus
);
    localparam int PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int WCW = $clog2(FRAME_TICKS + 1);
    localparam int SCW = $clog2(MOVE_STEPS + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DRAW, S_FLUSH, S_DONE,
        S_M_ERASE, S_M_STEP, S_M_DRAW, S_M_FLUSH, S_M_WAIT, S_MDONE
    } state_t;

    state_t         state, state_n;
    logic [11:0]    sel_q;
    logic [7:0]     ox;
    logic [6:0]     oy;
    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic [SCW-1:0] step_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           vld_d, erase_d;
    logic [7:0]     x_d;
    logic [6:0]     y_d;

    logic [3:0]     in_idx, q_idx;
    logic           in_ok, q_ok, sweeping, px_last, sweep_last, on_screen;
    logic [8:0]     x_full;
    logic [7:0]     y_full;
    logic [7:0]     dx;
    logic [6:0]     dy;

    function automatic logic [3:0] sel_index(input logic [11:0] s);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 12; i++)
            if (s[i]) r = 4'(i);
        return r;
    endfunction

    assign in_idx     = sel_index(bus.draw_sel);
    assign in_ok      = $onehot(bus.draw_sel);
    assign q_idx      = sel_index(sel_q);
    assign q_ok       = $onehot(sel_q);
    assign sweeping   = state inside {S_DRAW, S_M_DRAW, S_M_ERASE};
    assign px_last    = (px == PXW'(SPRITE_W - 1));
    assign sweep_last = px_last && (py == PYW'(SPRITE_H - 1));

    // Wide sums so a sprite straddling the right/bottom edge (or wrapped past 255) is clipped, not folded back.
    assign x_full    = {1'b0, ox} + 9'(px);
    assign y_full    = {1'b0, oy} + 8'(py);
    assign on_screen = (x_full < 9'(X_SCREEN_PIXELS)) && (y_full < 8'(Y_SCREEN_PIXELS));

    always_comb begin
        dx = '0;
        dy = '0;
        case (q_idx)
            4'd1:              dy = 7'h7f;
            4'd7, 4'd10, 4'd11: dx = 8'd2;
            4'd8:              dy = (step_cnt < SCW'(MOVE_STEPS / 2)) ? 7'h7e : 7'd2;
            4'd9:              dx = 8'hfe;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.move_req)      state_n = in_ok ? S_M_ERASE : S_MDONE;
                else if (bus.plot_req) state_n = in_ok ? S_LOAD : S_DONE;
            end
            S_LOAD:    state_n = S_DRAW;
            S_DRAW:    if (sweep_last) state_n = S_FLUSH;
            S_FLUSH:   state_n = S_DONE;
            S_DONE:    if (!bus.plot_req) state_n = S_IDLE;
            S_M_ERASE: if (sweep_last) state_n = S_M_STEP;
            S_M_STEP:  state_n = S_M_DRAW;
            S_M_DRAW:  if (sweep_last) state_n = S_M_FLUSH;
            S_M_FLUSH: state_n = S_M_WAIT;
            S_M_WAIT: begin
                if (wait_cnt == WCW'(FRAME_TICKS - 1))
                    state_n = (step_cnt < SCW'(MOVE_STEPS)) ? S_M_ERASE : S_MDONE;
            end
            S_MDONE:   if (!bus.move_req) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            sel_q    <= '0;
            ox       <= '0;
            oy       <= '0;
            px       <= '0;
            py       <= '0;
            step_cnt <= '0;
            wait_cnt <= '0;
            vld_d    <= 1'b0;
            erase_d  <= 1'b0;
            x_d      <= '0;
            y_d      <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && (bus.move_req || bus.plot_req)) begin
                sel_q    <= bus.draw_sel;
                ox       <= ORIGIN_X[int'(in_idx) * 8 +: 8];
                oy       <= ORIGIN_Y[int'(in_idx) * 7 +: 7];
                step_cnt <= '0;
            end
            if (state == S_M_STEP) begin
                ox       <= ox + dx;
                oy       <= oy + dy;
                step_cnt <= step_cnt + SCW'(1);
            end
            wait_cnt <= (state == S_M_WAIT) ? wait_cnt + WCW'(1) : '0;
            // Counters idle at zero, so every sweep starts from the top-left pixel.
            if (sweeping) begin
                px <= px_last ? '0 : px + PXW'(1);
                if (px_last)
                    py <= (py == PYW'(SPRITE_H - 1)) ? '0 : py + PYW'(1);
            end else begin
                px <= '0;
                py <= '0;
            end
            vld_d   <= sweeping && on_screen;
            erase_d <= (state == S_M_ERASE);
            x_d     <= x_full[7:0];
            y_d     <= y_full[6:0];
        end
    end

    assign bus.rom_addr = ROM_AW'(int'(q_idx) * SPRITE_W * SPRITE_H + int'(py) * SPRITE_W + int'(px));

    // Colour and transparency come straight from the ROM output, which lines up with the registered coordinates.
    assign bus.vga_x      = x_d;
    assign bus.vga_y      = y_d;
    assign bus.vga_colour = vld_d ? (erase_d ? BG_COLOUR : bus.rom_data) : 3'b000;
    assign bus.vga_plot   = vld_d && (erase_d || (bus.rom_data != 3'b000));

    assign bus.plot_busy = resetn &&
        ((state == S_IDLE && bus.plot_req && !bus.move_req) ||
         (state inside {S_LOAD, S_DRAW, S_FLUSH}));
    assign bus.move_busy = resetn &&
        ((state == S_IDLE && bus.move_req) ||
         (state inside {S_M_ERASE, S_M_STEP, S_M_DRAW, S_M_FLUSH, S_M_WAIT}));
    assign bus.bubble_drawn = (state == S_DONE) && q_ok && (|sel_q[6:2]);
endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter with a 4x4 sprite, 3-cycle frame wait and 2-step moves.
module tb_sprite_plotter;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int FT = 3;
    localparam int MS = 2;
    localparam logic [95:0] OXT = {8'd158, 8'd120, 8'd0, 8'd50, 8'd100, 8'd60,
                                   8'd60, 8'd60, 8'd60, 8'd30, 8'd80, 8'd10};
    localparam logic [83:0] OYT = {7'd10, 7'd10, 7'd60, 7'd100, 7'd50, 7'd70,
                                   7'd70, 7'd70, 7'd70, 7'd40, 7'd90, 7'd20};

    logic clk = 1'b0;
    logic resetn;

    sprite_plotter_if #(.ROM_AW(12)) bus();

    sprite_plotter #(
        .X_SCREEN_PIXELS(160), .Y_SCREEN_PIXELS(120),
        .SPRITE_W(W), .SPRITE_H(H), .ROM_AW(12),
        .FRAME_TICKS(FT), .MOVE_STEPS(MS), .BG_COLOUR(3'b011),
        .ORIGIN_X(OXT), .ORIGIN_Y(OYT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
        int k;
    } pix_t;

    typedef struct {
        string       name;
        logic [11:0] sel;
        int          idx;
        int          ox;
        int          oy;
        bit          valid;
        int          npix;
        int          busy_fall;
        bit          bubble;
    } vec_t;

    pix_t       got_q[$];
    pix_t       exp_q[$];
    logic [2:0] rom [0:4095];
    vec_t       vecs[7];
    int cyc = 0, r0 = 0, checks = 0, errors = 0, offscreen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    always @(negedge clk) begin
        pix_t p;
        if (bus.vga_plot) begin
            p.x = int'(bus.vga_x);
            p.y = int'(bus.vga_y);
            p.c = int'(bus.vga_colour);
            p.k = cyc - r0 - 1;
            got_q.push_back(p);
            if (bus.vga_x >= 8'd160 || bus.vga_y >= 7'd120) offscreen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic push_pix(input int x, input int y, input int c, input int k);
        pix_t p;
        if (c != 0 && x < 160 && y < 120) begin
            p.x = x % 256;
            p.y = y % 128;
            p.c = c;
            p.k = k;
            exp_q.push_back(p);
        end
    endtask

    task automatic plot_model(input int idx, input int ox, input int oy);
        exp_q.delete();
        for (int i = 0; i < W * H; i++)
            push_pix(ox + i % W, oy + i / W, int'(rom[idx * W * H + i]), 2 + i);
    endtask

    task automatic move_model(input int idx, input int ox, input int oy,
                              input int dx, input int dy0, input int dy1);
        int cx, cy, ke;
        cx = ox;
        cy = oy;
        exp_q.delete();
        for (int s = 0; s < MS; s++) begin
            ke = 1 + s * (2 * W * H + 2 + FT);
            for (int i = 0; i < W * H; i++)
                push_pix(cx + i % W, cy + i / W, 3, ke + i);
            cx = (cx + dx + 256) % 256;
            cy = (cy + ((s < MS / 2) ? dy0 : dy1) + 128) % 128;
            for (int i = 0; i < W * H; i++)
                push_pix(cx + i % W, cy + i / W, int'(rom[idx * W * H + i]), ke + W * H + 1 + i);
        end
    endtask

    task automatic cmp_pix(input string nm, input int npix);
        int n;
        check({nm, " pixel_count"}, got_q.size(), npix);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL %s pixel %0d: got (%0d,%0d) colour %0d cycle %0d, expected (%0d,%0d) colour %0d cycle %0d",
                         nm, i, got_q[i].x, got_q[i].y, got_q[i].c, got_q[i].k,
                         exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].k);
            end
        end
    endtask

    task automatic do_plot(input string nm, input logic [11:0] sel, input int exp_busy,
                           input bit exp_bub, input bit drop_early);
        int bk;
        bk = -1;
        got_q.delete();
        bus.draw_sel = sel;
        bus.move_req = 1'b0;
        bus.plot_req = 1'b1;
        r0 = cyc;
        #1 check({nm, " busy_in_req_cycle"}, bus.plot_busy, 1);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (drop_early) bus.plot_req = 1'b0;
            if (!bus.plot_busy) begin
                bk = cyc - r0 - 1;
                break;
            end
        end
        check({nm, " busy_fall_cycle"}, bk, exp_busy);
        check({nm, " bubble_at_done"}, bus.bubble_drawn, exp_bub);
        if (!drop_early) begin
            @(negedge clk);
            check({nm, " bubble_hold"}, {bus.bubble_drawn, bus.plot_busy}, {exp_bub, 1'b0});
            bus.plot_req = 1'b0;
            #1 check({nm, " bubble_at_drop"}, bus.bubble_drawn, exp_bub);
        end
        @(negedge clk);
        check({nm, " back_to_idle"}, {bus.bubble_drawn, bus.plot_busy}, 0);
    endtask

    task automatic do_move(input string nm, input logic [11:0] sel, input bit both,
                           input bit drop_early, input int exp_busy, input int npix);
        int bk, pb;
        bk = -1;
        pb = 0;
        got_q.delete();
        bus.draw_sel = sel;
        bus.move_req = 1'b1;
        bus.plot_req = both;
        r0 = cyc;
        #1 check({nm, " busy_in_req_cycle"}, {bus.move_busy, bus.plot_busy}, 2'b10);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (drop_early && n == 10) bus.move_req = 1'b0;
            if (bus.plot_busy) pb++;
            if (!bus.move_busy) begin
                bk = cyc - r0 - 1;
                break;
            end
        end
        check({nm, " busy_fall_cycle"}, bk, exp_busy);
        check({nm, " plot_busy_cycles"}, pb, 0);
        bus.move_req = 1'b0;
        bus.plot_req = 1'b0;
        repeat (2) @(negedge clk);
        check({nm, " back_to_idle"}, {bus.move_busy, bus.plot_busy, bus.bubble_drawn}, 0);
        cmp_pix(nm, npix);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 3'b101;
        rom[2 * W * H + 5] = 3'b000;

        vecs[0] = '{"pet",          12'h001, 0,  10,  20, 1'b1, 16, 18, 1'b0};
        vecs[1] = '{"hunger",       12'h004, 2,  30,  40, 1'b1, 15, 18, 1'b1};
        vecs[2] = '{"firstaid_edge",12'h800, 11, 158, 10, 1'b1, 8,  18, 1'b0};
        vecs[3] = '{"dying",        12'h040, 6,  60,  70, 1'b1, 16, 18, 1'b1};
        vecs[4] = '{"multi_003",    12'h003, 0,  0,   0,  1'b0, 0,  0,  1'b0};
        vecs[5] = '{"multi_bubble", 12'h00c, 0,  0,   0,  1'b0, 0,  0,  1'b0};
        vecs[6] = '{"zero_sel",     12'h000, 0,  0,   0,  1'b0, 0,  0,  1'b0};

        // Reset held with a plot request pending: everything must stay quiet.
        resetn = 1'b0;
        bus.plot_req = 1'b1;
        bus.move_req = 1'b0;
        bus.draw_sel = 12'h001;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs_zero",
                  {bus.plot_busy, bus.move_busy, bus.bubble_drawn, bus.vga_plot,
                   bus.vga_colour, bus.vga_x, bus.vga_y, bus.rom_addr}, 0);
        end
        resetn = 1'b1;
        plot_model(0, 10, 20);
        do_plot("reset_release_pet_early_drop", 12'h001, 18, 1'b0, 1'b1);
        cmp_pix("reset_release_pet_early_drop", 16);

        foreach (vecs[v]) begin
            if (vecs[v].valid) plot_model(vecs[v].idx, vecs[v].ox, vecs[v].oy);
            else exp_q.delete();
            do_plot(vecs[v].name, vecs[v].sel, vecs[v].busy_fall, vecs[v].bubble, 1'b0);
            cmp_pix(vecs[v].name, vecs[v].npix);
        end

        // Reset in the middle of a sweep must stop all pixel writes.
        bus.draw_sel = 12'h001;
        bus.plot_req = 1'b1;
        r0 = cyc;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        bus.plot_req = 1'b0;
        @(posedge clk);
        #1 got_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_plot_reset_pixels", got_q.size(), 0);
        check("mid_plot_reset_busy", {bus.plot_busy, bus.move_busy}, 0);

        move_model(7, 100, 50, 2, 0, 0);
        do_move("move_food_with_plot_req", 12'h080, 1'b1, 1'b0, 74, 64);
        move_model(9, 0, 60, -2, 0, 0);
        do_move("move_broom_wrap_early_drop", 12'h200, 1'b0, 1'b1, 74, 16);
        move_model(8, 50, 100, 0, -2, 2);
        do_move("move_ball_up_down", 12'h100, 1'b0, 1'b0, 74, 64);
        exp_q.delete();
        do_move("move_zero_sel", 12'h000, 1'b0, 1'b0, 0, 0);

        check("offscreen_pixels", offscreen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
